// File: rtl/weight_prefetch_controller.sv
// Weight-load sequencer: accepts per-layer kernel configs, streams the layer's weight words
// from the lockstepped banks into a ring of latch buffers and hands full buffers to compute.
module weight_prefetch_controller #(
   parameter int N_I            = 512,
   parameter int K_MAX          = 3,
   parameter int WEIGHT_STAGGER = 8,
   parameter int BANKDEPTH      = 1024,
   parameter int NUMBANKS       = 256,
   parameter int NUM_WBUF       = 2,
   parameter int AW             = $clog2(BANKDEPTH),
   parameter int BW             = $clog2(NUM_WBUF),
   localparam int KDW           = $clog2(K_MAX) + 1,
   localparam int NIW           = $clog2(N_I) + 1
) (
   input  logic                                      clk_i,
   input  logic                                      rst_ni,
   input  logic                                      soft_reset_i,
   input  logic                                      cfg_valid_i,
   output logic                                      cfg_ready_o,
   input  logic [KDW-1:0]                            cfg_kh_i,
   input  logic [KDW-1:0]                            cfg_kw_i,
   input  logic [NIW-1:0]                            cfg_ni_i,
   input  logic [AW-1:0]                             cfg_base_addr_i,
   output logic                                      cfg_err_o,
   input  logic [NUMBANKS-1:0]                       ocu_ready_i,
   input  logic [NUMBANKS-1:0]                       rw_collision_i,
   output logic                                      mem_req_o,
   output logic [AW-1:0]                             mem_addr_o,
   input  logic [NUMBANKS-1:0]                       mem_rvalid_i,
   output logic [WEIGHT_STAGGER*K_MAX*K_MAX-1:0]     weights_save_enable_o,
   output logic [BW-1:0]                             weights_save_bank_o,
   output logic [WEIGHT_STAGGER-1:0]                 weights_flush_o,
   output logic [BW-1:0]                             weights_read_bank_o,
   output logic                                      weights_valid_o,
   input  logic                                      bank_release_i,
   output logic                                      busy_o
);

   localparam int CPW = N_I / WEIGHT_STAGGER;
   localparam int DW  = $clog2(WEIGHT_STAGGER) + 1;
   localparam int TW  = $clog2(K_MAX * K_MAX * WEIGHT_STAGGER + 1);
   localparam int OW  = $clog2(NUM_WBUF + 1);
   localparam int NSE = WEIGHT_STAGGER * K_MAX * K_MAX;

   typedef enum logic [0:0] {S_IDLE = 1'b0, S_LOAD = 1'b1} state_t;

   function automatic logic f_dim_ok(input logic [KDW-1:0] d);
      return d[0] && (d <= KDW'(K_MAX));
   endfunction

   function automatic logic [DW-1:0] f_depth(input logic [NIW-1:0] ni);
      logic [NIW:0] t;
      t = ({1'b0, ni} + (NIW+1)'(CPW - 1)) / (NIW+1)'(CPW);
      return DW'(t);
   endfunction

   state_t          r_state, w_state_nxt;
   logic [KDW-1:0]  r_kh, r_kw, r_row_off, r_col_off, r_row, r_col;
   logic [DW-1:0]   r_dep;
   logic [AW-1:0]   r_base;
   logic [TW-1:0]   r_total, r_issued, r_saved;
   logic [OW-1:0]   r_occ;
   logic [BW-1:0]   r_wr_ptr, r_rd_ptr;
   logic            r_drop, r_cfg_err;

   logic            w_cfg_ok, w_ready, w_accept, w_load;
   logic            w_issue, w_save, w_done, w_release;
   logic [DW-1:0]   w_depth;
   logic [TW-1:0]   w_total;
   logic [AW:0]     w_addr_sum, w_addr_mod;
   logic [31:0]     w_se_idx;
   logic [WEIGHT_STAGGER-1:0] w_flush;

   assign w_cfg_ok  = f_dim_ok(cfg_kh_i) && f_dim_ok(cfg_kw_i) &&
                      (cfg_ni_i != '0) && (cfg_ni_i <= NIW'(N_I));
   assign w_ready   = (r_state == S_IDLE) && (r_occ < OW'(NUM_WBUF)) && !soft_reset_i;
   assign w_accept  = cfg_valid_i && w_ready;
   assign w_load    = w_accept && w_cfg_ok;
   assign w_depth   = f_depth(cfg_ni_i);
   assign w_total   = TW'(cfg_kh_i) * TW'(cfg_kw_i) * TW'(w_depth);

   assign w_issue   = (r_state == S_LOAD) && (&ocu_ready_i) && !(|rw_collision_i) &&
                      (r_issued < r_total);
   // A read issued under soft reset still returns; r_drop swallows that response.
   assign w_save    = (r_state == S_LOAD) && (&mem_rvalid_i) && !r_drop;
   assign w_done    = w_save && ((r_saved + TW'(1)) == r_total);
   assign w_release = bank_release_i && (r_occ != '0);

   assign w_addr_sum = {1'b0, r_base} + (AW+1)'(r_issued);
   assign w_addr_mod = (w_addr_sum >= (AW+1)'(BANKDEPTH)) ? (w_addr_sum - (AW+1)'(BANKDEPTH))
                                                          : w_addr_sum;
   assign w_se_idx   = 32'(r_dep) * 32'(K_MAX * K_MAX) +
                       (32'(r_row_off) + 32'(r_row)) * 32'(K_MAX) +
                       32'(r_col_off) + 32'(r_col);

   // Flush the stagger slices a smaller layer will not overwrite.
   always_comb begin
      w_flush = '0;
      if (w_load) begin
         for (int s = 0; s < WEIGHT_STAGGER; s++) begin
            w_flush[s] = (DW'(s) >= w_depth) || (cfg_kh_i < KDW'(K_MAX)) ||
                         (cfg_kw_i < KDW'(K_MAX));
         end
      end else begin
         w_flush = '0;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (soft_reset_i) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:  w_state_nxt = w_load ? S_LOAD : S_IDLE;
            S_LOAD:  w_state_nxt = w_done ? S_IDLE : S_LOAD;
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Layer parameters plus issue/save progress through depth-outer, pixel-inner order.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_kh <= '0; r_kw <= '0; r_row_off <= '0; r_col_off <= '0;
         r_base <= '0; r_total <= '0; r_issued <= '0; r_saved <= '0;
         r_row <= '0; r_col <= '0; r_dep <= '0;
         r_drop <= 1'b0; r_cfg_err <= 1'b0;
      end else if (soft_reset_i) begin
         r_kh <= '0; r_kw <= '0; r_row_off <= '0; r_col_off <= '0;
         r_base <= '0; r_total <= '0; r_issued <= '0; r_saved <= '0;
         r_row <= '0; r_col <= '0; r_dep <= '0;
         r_drop <= w_issue; r_cfg_err <= 1'b0;
      end else begin
         r_drop    <= 1'b0;
         r_cfg_err <= w_accept && !w_cfg_ok;
         if (w_load) begin
            r_kh      <= cfg_kh_i;
            r_kw      <= cfg_kw_i;
            r_row_off <= (KDW'(K_MAX) - cfg_kh_i) >> 1;
            r_col_off <= (KDW'(K_MAX) - cfg_kw_i) >> 1;
            r_base    <= cfg_base_addr_i;
            r_total   <= w_total;
            r_issued  <= '0;
            r_saved   <= '0;
            r_row     <= '0;
            r_col     <= '0;
            r_dep     <= '0;
         end else begin
            if (w_issue) begin
               r_issued <= r_issued + TW'(1);
            end
            if (w_save) begin
               r_saved <= r_saved + TW'(1);
               if (r_col == r_kw - KDW'(1)) begin
                  r_col <= '0;
                  if (r_row == r_kh - KDW'(1)) begin
                     r_row <= '0;
                     r_dep <= r_dep + DW'(1);
                  end else begin
                     r_row <= r_row + KDW'(1);
                  end
               end else begin
                  r_col <= r_col + KDW'(1);
               end
            end
         end
      end
   end

   // Buffer ring: completion fills the write slot, release frees the read slot.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_occ <= '0; r_wr_ptr <= '0; r_rd_ptr <= '0;
      end else if (soft_reset_i) begin
         r_occ <= '0; r_wr_ptr <= '0; r_rd_ptr <= '0;
      end else begin
         case ({w_done, w_release})
            2'b10:   r_occ <= r_occ + OW'(1);
            2'b01:   r_occ <= r_occ - OW'(1);
            default: r_occ <= r_occ;
         endcase
         if (w_done) begin
            r_wr_ptr <= r_wr_ptr + BW'(1);
         end
         if (w_release) begin
            r_rd_ptr <= r_rd_ptr + BW'(1);
         end
      end
   end

   assign cfg_ready_o           = w_ready;
   assign cfg_err_o             = r_cfg_err;
   assign mem_req_o             = w_issue;
   assign mem_addr_o            = AW'(w_addr_mod);
   assign weights_save_enable_o = w_save ? (NSE'(1'b1) << w_se_idx) : '0;
   assign weights_save_bank_o   = r_wr_ptr;
   assign weights_flush_o       = w_flush;
   assign weights_read_bank_o   = r_rd_ptr;
   assign weights_valid_o       = (r_occ != '0);
   assign busy_o                = (r_state == S_LOAD);

endmodule

// File: tb/tb_weight_prefetch_controller.sv
// Bench for weight_prefetch_controller: config table, directed multi-cycle sequences and
// random traffic, all checked cycle by cycle against a counter-and-arithmetic reference model.
module tb_weight_prefetch_controller;

   localparam int N_I = 64, K_MAX = 3, WS = 4, BANKDEPTH = 1024, NUMBANKS = 16, NUM_WBUF = 2;
   localparam int AW = 10, BW = 1, KDW = 3, NIW = 7, NSE = WS * K_MAX * K_MAX;

   logic                clk_i = 1'b0, rst_ni = 1'b0, soft_reset_i = 1'b0;
   logic                cfg_valid_i = 1'b0, bank_release_i = 1'b0;
   logic [KDW-1:0]      cfg_kh_i = '0, cfg_kw_i = '0;
   logic [NIW-1:0]      cfg_ni_i = '0;
   logic [AW-1:0]       cfg_base_addr_i = '0;
   logic [NUMBANKS-1:0] ocu_ready_i = '1, rw_collision_i = '0, mem_rvalid_i = '0;
   logic                cfg_ready_o, cfg_err_o, mem_req_o, weights_valid_o, busy_o;
   logic [AW-1:0]       mem_addr_o;
   logic [NSE-1:0]      weights_save_enable_o;
   logic [BW-1:0]       weights_save_bank_o, weights_read_bank_o;
   logic [WS-1:0]       weights_flush_o;

   weight_prefetch_controller #(
      .N_I(N_I), .K_MAX(K_MAX), .WEIGHT_STAGGER(WS), .BANKDEPTH(BANKDEPTH),
      .NUMBANKS(NUMBANKS), .NUM_WBUF(NUM_WBUF)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .soft_reset_i(soft_reset_i),
      .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
      .cfg_kh_i(cfg_kh_i), .cfg_kw_i(cfg_kw_i), .cfg_ni_i(cfg_ni_i),
      .cfg_base_addr_i(cfg_base_addr_i), .cfg_err_o(cfg_err_o),
      .ocu_ready_i(ocu_ready_i), .rw_collision_i(rw_collision_i),
      .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_rvalid_i(mem_rvalid_i),
      .weights_save_enable_o(weights_save_enable_o), .weights_save_bank_o(weights_save_bank_o),
      .weights_flush_o(weights_flush_o), .weights_read_bank_o(weights_read_bank_o),
      .weights_valid_o(weights_valid_o), .bank_release_i(bank_release_i), .busy_o(busy_o)
   );

   initial forever #5 clk_i = ~clk_i;

   int n_checks = 0, n_fail = 0;
   // reference model state
   bit m_loading = 0, m_err = 0, m_drop = 0, prev_req = 0;
   int m_occ = 0, m_wr = 0, m_rd = 0, m_issued = 0, m_saved = 0, m_total = 0;
   int m_kh = 1, m_kw = 1, m_base = 0;
   // observation logs
   int obs_addr[$], obs_save[$];
   int obs_err_cnt = 0, acc_cnt = 0;
   logic [WS-1:0]  obs_flush = '0;
   logic [NSE-1:0] last_se = '0;

   typedef struct {
      int kh, kw, ni, base, err;
      logic [WS-1:0] flush;
      int reads, first, last;
   } vec_t;
   vec_t vecs[12];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit rule_ok(input int kh, input int kw, input int ni);
      return (kh % 2 == 1) && (kh <= K_MAX) && (kw % 2 == 1) && (kw <= K_MAX) &&
             (ni >= 1) && (ni <= N_I);
   endfunction

   // One clock cycle: present rvalid, compare at the falling edge, advance the model.
   task automatic step();
      bit exp_ready, acc, okc, exp_issue, exp_save, done, rel;
      logic [WS-1:0]  exp_flush;
      logic [NSE-1:0] exp_se;
      int depth, kk, p, d, idx, kh, kw, ni;
      mem_rvalid_i = prev_req ? {NUMBANKS{1'b1}} : {NUMBANKS{1'b0}};
      #4;
      kh = int'(cfg_kh_i); kw = int'(cfg_kw_i); ni = int'(cfg_ni_i);
      exp_ready = !m_loading && (m_occ < NUM_WBUF) && !soft_reset_i;
      acc       = cfg_valid_i && exp_ready;
      okc       = rule_ok(kh, kw, ni);
      depth     = (ni + N_I / WS - 1) / (N_I / WS);
      exp_flush = '0;
      if (acc && okc)
         for (int s = 0; s < WS; s++) exp_flush[s] = (s >= depth) || (kh < K_MAX) || (kw < K_MAX);
      exp_issue = m_loading && (&ocu_ready_i) && !(|rw_collision_i) && (m_issued < m_total);
      exp_save  = m_loading && (&mem_rvalid_i) && !m_drop;
      exp_se    = '0;
      if (exp_save) begin
         kk  = m_kh * m_kw;
         p   = m_saved % kk;
         d   = m_saved / kk;
         idx = d * K_MAX * K_MAX + ((K_MAX - m_kh) / 2 + p / m_kw) * K_MAX + (K_MAX - m_kw) / 2 + p % m_kw;
         exp_se[idx] = 1'b1;
      end
      chk("cfg_ready", 64'(cfg_ready_o), 64'(exp_ready));
      chk("mem_req", 64'(mem_req_o), 64'(exp_issue));
      if (exp_issue) chk("mem_addr", 64'(mem_addr_o), 64'((m_base + m_issued) % BANKDEPTH));
      chk("save_en", 64'(weights_save_enable_o), 64'(exp_se));
      chk("flush", 64'(weights_flush_o), 64'(exp_flush));
      chk("save_bank", 64'(weights_save_bank_o), 64'(m_wr));
      chk("read_bank", 64'(weights_read_bank_o), 64'(m_rd));
      chk("wvalid", 64'(weights_valid_o), 64'(m_occ > 0));
      chk("busy", 64'(busy_o), 64'(m_loading));
      chk("cfg_err", 64'(cfg_err_o), 64'(m_err));
      if (mem_req_o) obs_addr.push_back(int'(mem_addr_o));
      for (int b = 0; b < NSE; b++) if (weights_save_enable_o[b]) obs_save.push_back(b);
      if (cfg_err_o) obs_err_cnt++;
      if (cfg_valid_i && cfg_ready_o) acc_cnt++;
      obs_flush = obs_flush | weights_flush_o;
      last_se   = weights_save_enable_o;
      done = exp_save && (m_saved + 1 == m_total);
      rel  = bank_release_i && (m_occ > 0);
      m_err = acc && !okc;
      if (soft_reset_i) begin
         m_loading = 0; m_occ = 0; m_wr = 0; m_rd = 0; m_issued = 0; m_saved = 0;
         m_drop = exp_issue;
      end else begin
         m_drop = 0;
         if (acc && okc) begin
            m_loading = 1; m_kh = kh; m_kw = kw; m_base = int'(cfg_base_addr_i);
            m_total = kh * kw * depth; m_issued = 0; m_saved = 0;
         end
         if (exp_issue) m_issued++;
         if (exp_save) m_saved++;
         if (done) m_loading = 0;
         if (done && !rel) m_occ++;
         else if (rel && !done) m_occ--;
         if (done) m_wr = (m_wr + 1) % NUM_WBUF;
         if (rel) m_rd = (m_rd + 1) % NUM_WBUF;
      end
      prev_req = mem_req_o;
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_cfg(input int kh, input int kw, input int ni, input int base);
      cfg_kh_i = KDW'(kh); cfg_kw_i = KDW'(kw); cfg_ni_i = NIW'(ni); cfg_base_addr_i = AW'(base);
   endtask

   task automatic clear_logs();
      obs_addr.delete(); obs_save.delete(); obs_err_cnt = 0; obs_flush = '0;
   endtask

   initial begin
      vecs[0]  = '{3, 3, 64, 'h010, 0, 4'b0000, 36, 'h010, 'h033};
      vecs[1]  = '{1, 3, 16, 'h000, 0, 4'b1111,  3, 'h000, 'h002};
      vecs[2]  = '{3, 3, 17, 'h100, 0, 4'b1100, 18, 'h100, 'h111};
      vecs[3]  = '{3, 1, 33, 'h3FE, 0, 4'b1111,  9, 'h3FE, 'h006};
      vecs[4]  = '{2, 3, 64, 'h000, 1, 4'b0000,  0, 0, 0};
      vecs[5]  = '{3, 3,  0, 'h000, 1, 4'b0000,  0, 0, 0};
      vecs[6]  = '{3, 3, 65, 'h000, 1, 4'b0000,  0, 0, 0};
      vecs[7]  = '{5, 3, 64, 'h000, 1, 4'b0000,  0, 0, 0};
      vecs[8]  = '{3, 0, 16, 'h000, 1, 4'b0000,  0, 0, 0};
      vecs[9]  = '{3, 3, 48, 'h200, 0, 4'b1000, 27, 'h200, 'h21A};
      vecs[10] = '{1, 1,  1, 'h3FF, 0, 4'b1111,  1, 'h3FF, 'h3FF};
      vecs[11] = '{1, 3, 16, 'h3FE, 0, 4'b1111,  3, 'h3FE, 'h000};

      // reset values while rst_ni is held low
      #12;
      chk("rst_ready", 64'(cfg_ready_o), 64'(1));
      chk("rst_req", 64'(mem_req_o), 64'(0));
      chk("rst_addr", 64'(mem_addr_o), 64'(0));
      chk("rst_se", 64'(weights_save_enable_o), 64'(0));
      chk("rst_flush", 64'(weights_flush_o), 64'(0));
      chk("rst_banks", 64'({weights_save_bank_o, weights_read_bank_o}), 64'(0));
      chk("rst_valid", 64'(weights_valid_o), 64'(0));
      chk("rst_err", 64'(cfg_err_o), 64'(0));
      chk("rst_busy", 64'(busy_o), 64'(0));
      rst_ni = 1'b1;
      @(posedge clk_i);
      #1;

      // config table: one layer per row, then release its buffer
      for (int v = 0; v < 12; v++) begin
         clear_logs();
         set_cfg(vecs[v].kh, vecs[v].kw, vecs[v].ni, vecs[v].base);
         cfg_valid_i = 1'b1;
         step();
         cfg_valid_i = 1'b0;
         for (int i = 0; i < 150 && m_loading; i++) step();
         step(); step();
         bank_release_i = 1'b1; step(); bank_release_i = 1'b0; step();
         chk($sformatf("v%0d_err", v), 64'(obs_err_cnt), 64'(vecs[v].err));
         chk($sformatf("v%0d_flush", v), 64'(obs_flush), 64'(vecs[v].flush));
         chk($sformatf("v%0d_reads", v), 64'(obs_addr.size()), 64'(vecs[v].reads));
         if (vecs[v].reads > 0 && obs_addr.size() > 0) begin
            chk($sformatf("v%0d_first", v), 64'(obs_addr[0]), 64'(vecs[v].first));
            chk($sformatf("v%0d_last", v), 64'(obs_addr[obs_addr.size()-1]), 64'(vecs[v].last));
         end
      end

      // full 3x3 layer with ocu_ready bit 7 low for 5 cycles mid-load
      soft_reset_i = 1'b1; step(); soft_reset_i = 1'b0;
      clear_logs();
      set_cfg(3, 3, 64, 'h010);
      cfg_valid_i = 1'b1; step(); cfg_valid_i = 1'b0;
      for (int i = 0; i < 100 && m_loading; i++) begin
         ocu_ready_i[7] = !(i >= 10 && i < 15);
         step();
      end
      ocu_ready_i = '1;
      chk("stall_valid", 64'(weights_valid_o), 64'(1));
      chk("stall_rbank", 64'(weights_read_bank_o), 64'(0));
      chk("stall_reads", 64'(obs_addr.size()), 64'(36));
      chk("stall_saves", 64'(obs_save.size()), 64'(36));
      for (int i = 0; i < obs_addr.size(); i++) chk("stall_addr", 64'(obs_addr[i]), 64'('h010 + i));
      for (int i = 0; i < obs_save.size(); i++) chk("stall_order", 64'(obs_save[i]), 64'(i));
      bank_release_i = 1'b1; step(); bank_release_i = 1'b0;

      // back-to-back configs fill both buffers, third waits for a release
      soft_reset_i = 1'b1; step(); soft_reset_i = 1'b0;
      acc_cnt = 0;
      set_cfg(1, 1, 64, 'h040);
      cfg_valid_i = 1'b1;
      for (int i = 0; i < 40; i++) step();
      chk("b2b_accepts", 64'(acc_cnt), 64'(2));
      chk("b2b_ready", 64'(cfg_ready_o), 64'(0));
      chk("b2b_valid", 64'(weights_valid_o), 64'(1));
      bank_release_i = 1'b1; step(); bank_release_i = 1'b0;
      chk("b2b_rbank", 64'(weights_read_bank_o), 64'(1));
      chk("b2b_wbank", 64'(weights_save_bank_o), 64'(0));
      step();
      cfg_valid_i = 1'b0;
      chk("b2b_third", 64'(acc_cnt), 64'(3));
      chk("b2b_busy", 64'(busy_o), 64'(1));
      for (int i = 0; i < 30 && m_loading; i++) step();
      bank_release_i = 1'b1; step(); step(); bank_release_i = 1'b0; step();

      // soft reset in an issue cycle: the returning read must not be saved
      set_cfg(3, 3, 64, 'h000);
      cfg_valid_i = 1'b1; step(); cfg_valid_i = 1'b0;
      step(); step(); step();
      chk("sr_issuing", 64'(mem_req_o), 64'(1));
      soft_reset_i = 1'b1; step(); soft_reset_i = 1'b0;
      step();
      chk("sr_no_save", 64'(last_se), 64'(0));
      chk("sr_ready", 64'(cfg_ready_o), 64'(1));
      chk("sr_busy", 64'(busy_o), 64'(0));
      chk("sr_valid", 64'(weights_valid_o), 64'(0));

      // random traffic against the model
      for (int i = 0; i < 800; i++) begin
         cfg_valid_i     = ($urandom % 4) == 0;
         cfg_kh_i        = KDW'($urandom_range(0, 5));
         cfg_kw_i        = KDW'($urandom_range(0, 5));
         cfg_ni_i        = NIW'($urandom_range(0, 70));
         cfg_base_addr_i = AW'($urandom);
         ocu_ready_i     = (($urandom % 5) != 0) ? {NUMBANKS{1'b1}} : NUMBANKS'($urandom);
         rw_collision_i  = (($urandom % 10) == 0) ? NUMBANKS'(1 << $urandom_range(0, NUMBANKS-1))
                                                  : {NUMBANKS{1'b0}};
         bank_release_i  = ($urandom % 6) == 0;
         soft_reset_i    = ($urandom % 60) == 0;
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/weight_prefetch_controller.md
Name: weight_prefetch_controller

Overview:
Weight-load sequencer for the OCU weight latch array, with NUM_WBUF latch buffers arranged as a ring. It accepts per-layer configs over a valid/ready handshake and prefetches up to NUM_WBUF layers ahead of compute. It supports rectangular odd kernels (kh x kw up to K_MAX), an explicit per-layer base address, and backpressure-tolerant read issue. It sits between the layer sequencer, the N_O/PIPELINEDEPTH weight memory banks (driven in lockstep) and the OCUs.

Parameters:
N_I, 512, input channels per OCU; must be divisible by WEIGHT_STAGGER.
K_MAX, 3, maximum kernel height/width; odd.
WEIGHT_STAGGER, 8, words per kernel pixel at full depth; each word carries N_I/WEIGHT_STAGGER channels.
BANKDEPTH, 1024, weight memory words per bank.
NUMBANKS, 256, lockstepped memory banks / OCU groups.
NUM_WBUF, 2, weight latch buffers; ≥2, power of two.
AW, $clog2(BANKDEPTH), address width.
BW, $clog2(NUM_WBUF), buffer index width.

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset
soft_reset_i  in  1  synchronous clear of all load state
cfg_valid_i  in  1  layer config offered
cfg_ready_o  out  1  config accepted when valid&ready
cfg_kh_i, cfg_kw_i  in  $clog2(K_MAX)+1  kernel height/width
cfg_ni_i  in  $clog2(N_I)+1  layer input channels
cfg_base_addr_i  in  AW  first weight word address
cfg_err_o  out  1  one-cycle pulse: invalid config consumed
ocu_ready_i  in  NUMBANKS  all bits must be 1 to issue
rw_collision_i  in  NUMBANKS  any bit 1 blocks issue
mem_req_o  out  1  read strobe
mem_addr_o  out  AW  read address
mem_rvalid_i  in  NUMBANKS  read data valid (all 1 = valid)
weights_save_enable_o  out  WEIGHT_STAGGER*K_MAX*K_MAX  one-hot latch write enable
weights_save_bank_o  out  BW  buffer being loaded
weights_flush_o  out  WEIGHT_STAGGER  clear stagger slices of save bank
weights_read_bank_o  out  BW  buffer used by compute
weights_valid_o  out  1  read bank holds a complete layer
bank_release_i  in  1  compute finished with read bank
busy_o  out  1  load in progress

Behaviour:
- Reset: FSM IDLE; wr_ptr=rd_ptr=occ=0; all counters 0. Outputs reset: mem_req_o=0, mem_addr_o=0, weights_* enables/flush=0, weights_save_bank_o=0, weights_read_bank_o=0, weights_valid_o=0, cfg_ready_o=1, cfg_err_o=0, busy_o=0.
- cfg_ready_o = (state==IDLE) && occ<NUM_WBUF && !soft_reset_i.
- Config is valid iff kh and kw are odd and in 1..K_MAX, and 1 ≤ ni ≤ N_I.
- Invalid config on accept: cfg_err_o pulses for 1 cycle; no reads are issued; state and occ are unchanged.
- Valid config on accept: latch kh, kw, base; depth = ceil(ni/(N_I/WEIGHT_STAGGER)) (range 1..WEIGHT_STAGGER); total = kh*kw*depth.
- Flush on valid accept (same cycle, applies to wr_ptr): weights_flush_o[s]=1 for s ≥ depth; all bits 1 if kh<K_MAX or kw<K_MAX. Then IDLE→LOAD.
- LOAD, issue side:
  - issue = ocu_ready_i all-ones && rw_collision_i all-zero && issued<total.
  - mem_req_o = issue; mem_addr_o = (base + issued) mod BANKDEPTH; issued increments on issue.
  - At most one read per cycle. Fixed read latency 1: rvalid arrives the cycle after issue.
- LOAD, save side: on mem_rvalid_i all-ones with no drop pending, assert exactly one weights_save_enable_o bit, in the same cycle (combinational from rvalid):
  - stagger = d; row = (K_MAX-kh)/2 + p/kw; col = (K_MAX-kw)/2 + p%kw.
  - Order: p counts 0..kh*kw-1 and wraps to 0, then d increments. Depth is the outer loop, pixel row-major the inner loop.
  - saved increments on each save.
- Completion: when saved reaches total, LOAD→IDLE next cycle; occ += 1; wr_ptr = (wr_ptr+1) mod NUM_WBUF.
- Release: bank_release_i with occ>0 gives occ -= 1 and rd_ptr += 1. bank_release_i with occ==0 is ignored.
- Release in the same cycle as completion: occ unchanged; both pointers advance.
- weights_valid_o = occ>0. busy_o = (state==LOAD).
- Soft reset, effective next cycle: FSM IDLE; occ, pointers and counters cleared. If a read was issued in the soft-reset cycle, the drop flag is set and the next cycle's rvalid produces no save enable. soft_reset_i takes priority over cfg accept, issue and release in the same cycle.
- Wrap: address wraps modulo BANKDEPTH silently.

Test Plan:
Common setup: K_MAX=3, WEIGHT_STAGGER=4, N_I=64, NUM_WBUF=2, memory model with 1-cycle latency.
1. cfg kh=kw=3, ni=64, base=0x10 → 36 reads at 0x10..0x33; first save stagger0(0,0); 10th save stagger1(0,0); last save stagger3(2,2); weights_valid_o=1 one cycle after the 36th rvalid; read bank 0.
2. cfg kh=1, kw=3, ni=16, base=0 → flush=4'b1111; 3 reads; saves stagger0 at (1,0),(1,1),(1,2); total=3.
3. Two valid configs back-to-back → occ=2, cfg_ready_o=0, third cfg stalls; bank_release_i → read bank 0→1, third cfg accepted next cycle, loads into buffer 0.
4. ocu_ready_i bit 7 low for 5 cycles mid-load → mem_req_o=0, address held; still exactly 36 reads, no duplicate addresses, save order intact.
5. soft_reset_i during an issue cycle → following rvalid yields no save enable; occ=0, cfg_ready_o=1, busy_o=0.
6. cfg kh=2 → cfg_err_o one-cycle pulse, mem_req_o stays 0, occ unchanged; base=0x3FE with 3 words → addresses 0x3FE, 0x3FF, 0x000.
